// File: rtl/s5378.sv
// 179-flop scan chain with PI-injected capture and feedback taps; POs are a
// purely combinational XOR of two chain bits and one primary input.
module s5378 (
  input  logic CK,
  input  logic RST,
  input  logic n3065gat, n3066gat, n3067gat, n3068gat, n3069gat, n3070gat, n3071gat,
  input  logic n3072gat, n3073gat, n3074gat, n3075gat, n3076gat, n3077gat, n3078gat,
  input  logic n3079gat, n3080gat, n3081gat, n3082gat, n3083gat, n3084gat, n3085gat,
  input  logic n3086gat, n3087gat, n3088gat, n3089gat, n3090gat, n3091gat, n3092gat,
  input  logic n3093gat, n3094gat, n3095gat, n3097gat, n3098gat, n3099gat, n3100gat,
  output logic n3104gat, n3105gat, n3106gat, n3107gat, n3108gat, n3109gat, n3110gat,
  output logic n3111gat, n3112gat, n3113gat, n3114gat, n3115gat, n3116gat, n3117gat,
  output logic n3118gat, n3119gat, n3120gat, n3121gat, n3122gat, n3123gat, n3124gat,
  output logic n3125gat, n3126gat, n3127gat, n3128gat, n3129gat, n3130gat, n3131gat,
  output logic n3132gat, n3133gat, n3134gat, n3135gat, n3136gat, n3137gat, n3138gat,
  output logic n3139gat, n3140gat, n3141gat, n3142gat, n3143gat, n3144gat, n3145gat,
  output logic n3146gat, n3147gat, n3148gat, n3149gat, n3150gat, n3151gat, n3152gat,
  input  logic test_se,
  input  logic test_si,
  output logic test_so
);

  localparam int unsigned NS  = 179;
  localparam int unsigned NPI = 35;
  localparam int unsigned NPO = 49;

  logic [NPI-1:0] pi;
  logic [NPO-1:0] po;
  logic [NS-1:0]  s_q, s_d, fb_mask;

  // n3096gat does not exist, so PI[31] is n3097gat.
  assign pi = {n3100gat, n3099gat, n3098gat, n3097gat,
               n3095gat, n3094gat, n3093gat, n3092gat, n3091gat, n3090gat, n3089gat,
               n3088gat, n3087gat, n3086gat, n3085gat, n3084gat, n3083gat, n3082gat,
               n3081gat, n3080gat, n3079gat, n3078gat, n3077gat, n3076gat, n3075gat,
               n3074gat, n3073gat, n3072gat, n3071gat, n3070gat, n3069gat, n3068gat,
               n3067gat, n3066gat, n3065gat};

  always_comb begin
    fb_mask      = '0;
    fb_mask[7]   = s_q[NS-1];
    fb_mask[70]  = s_q[NS-1];
    fb_mask[140] = s_q[NS-1];
    if (test_se) begin
      s_d = {s_q[NS-2:0], test_si};
    end else begin
      // rotate puts S[178] into bit 0, covering N[0]=F^PI[0]
      s_d = {s_q[NS-2:0], s_q[NS-1]} ^ {{(NS-NPI){1'b0}}, pi} ^ fb_mask;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) s_q <= '0;
    else     s_q <= s_d;
  end

  always_comb begin
    po = '0;
    for (int unsigned i = 0; i < NPO; i++) begin
      po[i] = s_q[i] ^ s_q[i+NPO] ^ pi[i%NPI];
    end
  end

  assign test_so = s_q[NS-1];

  assign {n3110gat, n3109gat, n3108gat, n3107gat, n3106gat, n3105gat, n3104gat} = po[6:0];
  assign {n3117gat, n3116gat, n3115gat, n3114gat, n3113gat, n3112gat, n3111gat} = po[13:7];
  assign {n3124gat, n3123gat, n3122gat, n3121gat, n3120gat, n3119gat, n3118gat} = po[20:14];
  assign {n3131gat, n3130gat, n3129gat, n3128gat, n3127gat, n3126gat, n3125gat} = po[27:21];
  assign {n3138gat, n3137gat, n3136gat, n3135gat, n3134gat, n3133gat, n3132gat} = po[34:28];
  assign {n3145gat, n3144gat, n3143gat, n3142gat, n3141gat, n3140gat, n3139gat} = po[41:35];
  assign {n3152gat, n3151gat, n3150gat, n3149gat, n3148gat, n3147gat, n3146gat} = po[48:42];

endmodule

// File: tb/tb_s5378.sv
// Randomized and directed bench for s5378 against a loop-based chain model.
module tb_s5378;

  logic        CK, RST, test_se, test_si, test_so;
  logic [34:0] pi;
  logic [48:0] po;
  logic [178:0] m;
  int total, bad;

  s5378 dut (
    .CK(CK), .RST(RST),
    .n3065gat(pi[0]),  .n3066gat(pi[1]),  .n3067gat(pi[2]),  .n3068gat(pi[3]),
    .n3069gat(pi[4]),  .n3070gat(pi[5]),  .n3071gat(pi[6]),  .n3072gat(pi[7]),
    .n3073gat(pi[8]),  .n3074gat(pi[9]),  .n3075gat(pi[10]), .n3076gat(pi[11]),
    .n3077gat(pi[12]), .n3078gat(pi[13]), .n3079gat(pi[14]), .n3080gat(pi[15]),
    .n3081gat(pi[16]), .n3082gat(pi[17]), .n3083gat(pi[18]), .n3084gat(pi[19]),
    .n3085gat(pi[20]), .n3086gat(pi[21]), .n3087gat(pi[22]), .n3088gat(pi[23]),
    .n3089gat(pi[24]), .n3090gat(pi[25]), .n3091gat(pi[26]), .n3092gat(pi[27]),
    .n3093gat(pi[28]), .n3094gat(pi[29]), .n3095gat(pi[30]), .n3097gat(pi[31]),
    .n3098gat(pi[32]), .n3099gat(pi[33]), .n3100gat(pi[34]),
    .n3104gat(po[0]),  .n3105gat(po[1]),  .n3106gat(po[2]),  .n3107gat(po[3]),
    .n3108gat(po[4]),  .n3109gat(po[5]),  .n3110gat(po[6]),  .n3111gat(po[7]),
    .n3112gat(po[8]),  .n3113gat(po[9]),  .n3114gat(po[10]), .n3115gat(po[11]),
    .n3116gat(po[12]), .n3117gat(po[13]), .n3118gat(po[14]), .n3119gat(po[15]),
    .n3120gat(po[16]), .n3121gat(po[17]), .n3122gat(po[18]), .n3123gat(po[19]),
    .n3124gat(po[20]), .n3125gat(po[21]), .n3126gat(po[22]), .n3127gat(po[23]),
    .n3128gat(po[24]), .n3129gat(po[25]), .n3130gat(po[26]), .n3131gat(po[27]),
    .n3132gat(po[28]), .n3133gat(po[29]), .n3134gat(po[30]), .n3135gat(po[31]),
    .n3136gat(po[32]), .n3137gat(po[33]), .n3138gat(po[34]), .n3139gat(po[35]),
    .n3140gat(po[36]), .n3141gat(po[37]), .n3142gat(po[38]), .n3143gat(po[39]),
    .n3144gat(po[40]), .n3145gat(po[41]), .n3146gat(po[42]), .n3147gat(po[43]),
    .n3148gat(po[44]), .n3149gat(po[45]), .n3150gat(po[46]), .n3151gat(po[47]),
    .n3152gat(po[48]),
    .test_se(test_se), .test_si(test_si), .test_so(test_so)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  function automatic logic [178:0] m_shift(input logic [178:0] s, input logic si);
    logic [178:0] r;
    for (int i = 178; i > 0; i--) r[i] = s[i-1];
    r[0] = si;
    return r;
  endfunction

  function automatic logic [178:0] m_capture(input logic [178:0] s, input logic [34:0] p);
    logic [178:0] r;
    logic f;
    f = s[178];
    for (int i = 0; i < 179; i++) begin
      r[i] = (i == 0) ? f : s[i-1];
      if (i < 35) r[i] = r[i] ^ p[i];
      if (i == 7 || i == 70 || i == 140) r[i] = r[i] ^ f;
    end
    return r;
  endfunction

  function automatic logic [48:0] m_po(input logic [178:0] s, input logic [34:0] p);
    logic [48:0] r;
    for (int i = 0; i < 49; i++) r[i] = s[i] ^ s[i+49] ^ p[i%35];
    return r;
  endfunction

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    m = '0;
  endtask

  task automatic shift_in(input logic si);
    test_se = 1'b1;
    test_si = si;
    tick();
    m = m_shift(m, si);
  endtask

  task automatic capture(input logic [34:0] p);
    test_se = 1'b0;
    pi = p;
    tick();
    m = m_capture(m, p);
  endtask

  task automatic load(input logic [178:0] v);
    for (int k = 0; k < 179; k++) shift_in(v[178-k]);
  endtask

  task automatic unload(output logic [178:0] got);
    for (int k = 0; k < 179; k++) begin
      #1;
      got[178-k] = test_so;
      shift_in(1'b0);
    end
  endtask

  task automatic test_reset();
    pi = '0;
    test_se = 1'b0;
    do_reset();
    #1;
    total++;
    if (test_so !== 1'b0) begin bad++; $display("FAIL reset_so got=%b exp=0", test_so); end
    total++;
    if (po !== 49'd0) begin bad++; $display("FAIL reset_po_zero got=%h exp=0", po); end
    pi = '1;
    #1;
    total++;
    if (po !== {49{1'b1}}) begin bad++; $display("FAIL reset_po_ones got=%h exp=all1", po); end
    pi = '0;
  endtask

  task automatic test_shift_latency();
    do_reset();
    for (int k = 1; k <= 179; k++) begin
      shift_in(1'b1);
      total++;
      if (test_so !== (k == 179)) begin
        bad++; $display("FAIL shift_latency edge=%0d got=%b exp=%b", k, test_so, (k == 179));
      end
    end
  endtask

  task automatic test_round_trip();
    logic [178:0] v;
    for (int i = 0; i < 179; i++) v[i] = (i % 2 == 0);
    do_reset();
    load(v);
    for (int k = 0; k < 179; k++) begin
      #1;
      total++;
      if (test_so !== v[178-k]) begin
        bad++; $display("FAIL round_trip k=%0d got=%b exp=%b", k, test_so, v[178-k]);
      end
      shift_in(1'b0);
    end
  endtask

  task automatic test_capture_pi();
    logic [178:0] got, exp;
    exp = '0;
    exp[34:0] = '1;
    do_reset();
    capture('1);
    pi = '0;
    unload(got);
    total++;
    if (got !== exp) begin bad++; $display("FAIL capture_pi got=%h exp=%h", got, exp); end
  endtask

  task automatic test_capture_feedback();
    logic [178:0] got, exp, v;
    v = '0; v[178] = 1'b1;
    exp = '0; exp[0] = 1'b1; exp[7] = 1'b1; exp[70] = 1'b1; exp[140] = 1'b1;
    do_reset();
    pi = '0;
    load(v);
    capture('0);
    unload(got);
    total++;
    if (got !== exp) begin bad++; $display("FAIL capture_fb got=%h exp=%h", got, exp); end
  endtask

  task automatic test_po_map();
    logic [178:0] v;
    pi = '0;
    v = '0; v[0] = 1'b1;
    do_reset(); load(v); #1;
    total++;
    if (po !== 49'd1) begin bad++; $display("FAIL po_map_s0 got=%h exp=1", po); end
    v = '0; v[49] = 1'b1;
    do_reset(); load(v); #1;
    total++;
    if (po !== 49'd1) begin bad++; $display("FAIL po_map_s49 got=%h exp=1", po); end
    v[0] = 1'b1;
    do_reset(); load(v); #1;
    total++;
    if (po !== 49'd0) begin bad++; $display("FAIL po_map_both got=%h exp=0", po); end
  endtask

  task automatic test_mid_shift_reset();
    do_reset();
    for (int k = 0; k < 60; k++) shift_in(1'b1);
    do_reset();
    for (int k = 1; k <= 179; k++) begin
      shift_in(1'b0);
      total++;
      if (test_so !== 1'b0) begin bad++; $display("FAIL mid_reset edge=%0d got=%b exp=0", k, test_so); end
    end
  endtask

  task automatic test_random();
    logic [63:0] r64;
    logic [178:0] got;
    logic se_final, si_r;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r64 = {$urandom(), $urandom()};
      pi = r64[34:0];
      se_final = ($urandom_range(0, 2) != 0);
      si_r = $urandom_range(0, 1);
      test_si = si_r;
      test_se = ~se_final;
      #2;
      test_se = se_final;
      #1;
      total++;
      if (po !== m_po(m, pi)) begin bad++; $display("FAIL random_po c=%0d got=%h exp=%h", c, po, m_po(m, pi)); end
      total++;
      if (test_so !== m[178]) begin bad++; $display("FAIL random_so c=%0d got=%b exp=%b", c, test_so, m[178]); end
      if ($urandom_range(0, 24) == 0) begin
        do_reset();
      end else begin
        tick();
        m = se_final ? m_shift(m, si_r) : m_capture(m, pi);
      end
    end
    pi = '0;
    begin
      logic [178:0] exp;
      exp = m;
      unload(got);
      total++;
      if (got !== exp) begin bad++; $display("FAIL random_final got=%h exp=%h", got, exp); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    RST = 1'b0; test_se = 1'b0; test_si = 1'b0; pi = '0; m = '0;
    test_reset();
    test_shift_latency();
    test_round_trip();
    test_capture_pi();
    test_capture_feedback();
    test_po_map();
    test_mid_shift_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/s5378.md
S5378 -- requirements
Module: s5378

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 CK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 n3065gat..n3095gat, n3097gat..n3100gat  input  1 each  35 primary inputs; there SHALL be no n3096gat. PI[0]=n3065gat ascending to PI[30]=n3095gat, PI[31]=n3097gat .. PI[34]=n3100gat.
REQ-005 n3104gat..n3152gat  output  1 each  49 primary outputs, PO[0]=n3104gat .. PO[48]=n3152gat.
REQ-006 test_se  input  1  scan enable; 1=shift, 0=functional capture.
REQ-007 test_si  input  1  scan serial input.
REQ-008 test_so  output  1  scan serial output.

Function
REQ-009 The block SHALL contain exactly 179 state flip-flops S[178:0], all forming one scan chain.
REQ-010 test_so SHALL equal S[178] combinationally.
REQ-011 When RST=0 and test_se=1, each rising CK edge SHALL perform: S[0]<=test_si; S[i]<=S[i-1] for i=1..178; PIs ignored.
REQ-012 After 179 shift edges with test_si presenting V[178] first down to V[0] last, S SHALL equal V bit-for-bit.
REQ-013 When RST=0 and test_se=0, each rising CK edge SHALL capture N into S, where F=S[178]:
- N[0]=F^PI[0]
- N[i]=S[i-1]^PI[i] for i=1..34
- N[i]=S[i-1] for i=35..178
- additionally, N[7], N[70] and N[140] SHALL each be XORed with F.
REQ-014 PO[i] SHALL be the combinational function S[i]^S[i+49]^PI[i mod 35] for i=0..48, with no registering and zero-cycle latency.
REQ-015 test_se SHALL be sampled only at the clock edge; changing it between edges SHALL have no effect until the next edge.
REQ-016 The block SHALL contain no X-producing logic; all outputs SHALL be defined whenever S is defined.

Reset
REQ-017 RST=1 at a rising CK edge SHALL clear S[178:0] to 0, overriding both shift and capture.
REQ-018 After reset, test_so SHALL be 0 and PO[i] SHALL equal PI[i mod 35].
REQ-019 RST asserted mid-shift SHALL discard the partial chain contents; shifting SHALL restart from the all-zero state after RST deasserts.
REQ-020 Before the first reset, the S contents SHALL be unspecified. No other state SHALL exist.

Verification
REQ-021 Reset: RST=1 for one edge, all PI=0 -> test_so=0 and all 49 POs=0; with PI all ones, PO[i]=1 for all i.
REQ-022 Shift latency: after reset, test_se=1, test_si=1 for 178 edges -> test_so=0; on the 179th edge -> test_so=1.
REQ-023 Round trip: shift in alternating V=1010...(V[178]=1) over 179 edges, then shift with test_si=0 -> test_so before each successive edge reads V[178], V[177], .. V[0].
REQ-024 Capture with PI injection: S=0, PI all ones, test_se=0, one edge -> S[34:0] all ones, S[178:35]=0.
REQ-025 Capture with feedback: S has only S[178]=1, PI=0, one capture edge -> S has ones exactly at bits 0, 7, 70, 140.
REQ-026 PO mapping: S has only S[0]=1, PI=0 -> PO[0]=1, others 0; S has only S[49]=1 -> PO[0]=1; with both set -> PO[0]=0.
